// File: rtl/dff_toggle_monitor.sv
// Toggle/compare monitor for a flip-flop output q over a programmable window.
// Latency: ARM takes 1 cycle, RUN takes max(win_len,1) cycles; each event shows on the outputs one cycle later.
// Backpressure: none. A start pulse is taken only in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk_i        clock, all logic on posedge
//   reset_i      synchronous active-low reset
//   start_i      one-cycle pulse that begins a window (accepted in IDLE/DONE)
//   win_len_i    window length in cycles, sampled on accepted start (0 acts as 1)
//   q_i          observed flip-flop output
//   exp_q_i      expected q for the same cycle
//   chk_en_i     qualifies exp_q_i
//   busy_o       window armed or running
//   done_o       window finished; outputs hold until the next accepted start
//   rise_cnt_o   0->1 transitions in the window (saturating)
//   fall_cnt_o   1->0 transitions in the window (saturating)
//   err_cnt_o    qualified mismatches in the window (saturating)
//   first_err_o  window index of the first mismatch, all-ones if none
//   err_flag_o   err_cnt_o != 0
//
// Build option: define DFF_TOGGLE_MONITOR_GLITCH_FILTER_EN to run q through a
// 2-sample stability filter before edge detection (mismatch compare stays raw).
module dff_toggle_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             q_i,
  input  logic             exp_q_i,
  input  logic             chk_en_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] rise_cnt_o,
  output logic [CNT_W-1:0] fall_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [WIN_W-1:0] first_err_o,
  output logic             err_flag_o
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] IDX_NONE = '1;
  localparam logic [WIN_W-1:0] IDX_ONE  = WIN_W'(1);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] idx_q, idx_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] first_err_q, first_err_d;
  logic [CNT_W-1:0] rise_q, rise_d;
  logic [CNT_W-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] err_q, err_d;
  // Last value seen by the edge detector (filtered value when the filter is built in).
  logic             q_prev_q, q_prev_d;
  logic             edge_src;
  logic             rise_ev, fall_ev, mis_ev;

`ifdef DFF_TOGGLE_MONITOR_GLITCH_FILTER_EN
  // Previous raw sample; the filtered value follows q only once two
  // consecutive samples agree, otherwise it holds.
  logic q_smp_q, q_smp_d;
  always_comb edge_src = (q_i == q_smp_q) ? q_i : q_prev_q;
`else
  always_comb edge_src = q_i;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    first_err_d = first_err_q;
    rise_d      = rise_q;
    fall_d      = fall_q;
    err_d       = err_q;
    q_prev_d    = q_prev_q;
`ifdef DFF_TOGGLE_MONITOR_GLITCH_FILTER_EN
    q_smp_d     = q_smp_q;
`endif
    rise_ev     = edge_src & ~q_prev_q;
    fall_ev     = ~edge_src & q_prev_q;
    mis_ev      = chk_en_i & (q_i ^ exp_q_i);

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = ARM;
          len_d   = (win_len_i == '0) ? IDX_ONE : win_len_i;
        end
      end
      ARM: begin
        state_d     = RUN;
        q_prev_d    = q_i;
`ifdef DFF_TOGGLE_MONITOR_GLITCH_FILTER_EN
        q_smp_d     = q_i;
`endif
        idx_d       = '0;
        rise_d      = '0;
        fall_d      = '0;
        err_d       = '0;
        first_err_d = IDX_NONE;
      end
      RUN: begin
        if (rise_ev && rise_q != CNT_MAX) rise_d = rise_q + 1'b1;
        if (fall_ev && fall_q != CNT_MAX) fall_d = fall_q + 1'b1;
        if (mis_ev) begin
          if (err_q != CNT_MAX) err_d = err_q + 1'b1;
          // err_q saturates rather than wrapping, so zero means no earlier mismatch.
          if (err_q == '0) first_err_d = idx_q;
        end
        q_prev_d = edge_src;
`ifdef DFF_TOGGLE_MONITOR_GLITCH_FILTER_EN
        q_smp_d  = q_i;
`endif
        idx_d    = idx_q + IDX_ONE;
        if (idx_q == len_q - IDX_ONE) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      first_err_q <= IDX_NONE;
      rise_q      <= '0;
      fall_q      <= '0;
      err_q       <= '0;
      q_prev_q    <= 1'b0;
`ifdef DFF_TOGGLE_MONITOR_GLITCH_FILTER_EN
      q_smp_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      first_err_q <= first_err_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      err_q       <= err_d;
      q_prev_q    <= q_prev_d;
`ifdef DFF_TOGGLE_MONITOR_GLITCH_FILTER_EN
      q_smp_q     <= q_smp_d;
`endif
    end
  end

  assign busy_o      = (state_q == ARM) || (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign rise_cnt_o  = rise_q;
  assign fall_cnt_o  = fall_q;
  assign err_cnt_o   = err_q;
  assign first_err_o = first_err_q;
  assign err_flag_o  = (err_q != '0);

endmodule
